// File: rtl/ddr_game_ctrl.sv
// -----------------------------------------------------------------------------
// ddr_game_ctrl
//
// Round sequencer for the DDR game: IDLE -> COUNT -> PLAY -> DONE.
// During PLAY it times each chart step in frames, collects the debounced lane
// presses that land inside the judgment window at the end of the step, judges
// the step (HIT / MISS / rest), keeps score, combo and lives, and pulses
// next_o to advance the chart to its next step.
//
// Parameters
//   COUNTDOWN_FRAMES : frames spent in COUNT before play starts (1..255)
//   WINDOW           : frames before step end during which presses count (1..128)
//   SCORE_W          : score width (>= 5)
//   LIVES            : misses allowed per round (1..3)
//
// Ports
//   clk_i        in   pixel clock
//   rst_i        in   asynchronous active-high reset
//   frame_i      in   one-cycle pulse per frame
//   start_i      in   one-cycle start pulse
//   btn_i[3:0]   in   one-cycle press pulses {right, down, up, left}
//   arrows_i[3:0]in   required arrows of the current chart step
//   timing_i[3:0]in   step length code, L = (timing_i+1)*8 frames
//   next_o       out  one-cycle chart advance pulse
//   state_o[1:0] out  IDLE=0, COUNT=1, PLAY=2, DONE=3
//   step_frame_o out  frames elapsed in the current step
//   score_o      out  accumulated score (saturating)
//   combo_o      out  consecutive hits (saturating at 255)
//   lives_o      out  remaining lives
//   judge_o      out  last judgment: 0 none, 1 HIT, 2 MISS
// -----------------------------------------------------------------------------
module ddr_game_ctrl #(
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int WINDOW           = 8,
    parameter int SCORE_W          = 16,
    parameter int LIVES            = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_i,
    input  logic               start_i,
    input  logic [3:0]         btn_i,
    input  logic [3:0]         arrows_i,
    input  logic [3:0]         timing_i,
    output logic               next_o,
    output logic [1:0]         state_o,
    output logic [7:0]         step_frame_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [7:0]         combo_o,
    output logic [1:0]         lives_o,
    output logic [1:0]         judge_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]       COUNT_LOAD = 8'(COUNTDOWN_FRAMES - 1);
    localparam logic [7:0]       WINDOW_L   = 8'(WINDOW);
    localparam logic [1:0]       LIVES_L    = 2'(LIVES);
    localparam logic [SCORE_W:0] BONUS_LO   = (SCORE_W+1)'(10);
    localparam logic [SCORE_W:0] BONUS_HI   = (SCORE_W+1)'(20);

    localparam logic [1:0] JUDGE_NONE = 2'd0;
    localparam logic [1:0] JUDGE_HIT  = 2'd1;
    localparam logic [1:0] JUDGE_MISS = 2'd2;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             state_q;
    logic [7:0]         count_q;
    logic [7:0]         step_frame_q;
    logic [3:0]         pressed_q;
    logic               wrong_q;
    logic [SCORE_W-1:0] score_q;
    logic [7:0]         combo_q;
    logic [1:0]         lives_q;
    logic [1:0]         judge_q;
    logic               next_q;

    // -------------------------------------------------------------------------
    // Chart decode (combinational from the chart's current step)
    // -------------------------------------------------------------------------
    logic [7:0] step_len;
    logic [7:0] step_last;
    logic [7:0] win_start;
    logic       end_marker;
    logic       rest_step;
    logic       in_window;

    // (timing_i+1)*8 peaks at 128, so 8 bits are enough.
    assign step_len   = {1'b0, timing_i, 3'b000} + 8'd8;
    assign step_last  = step_len - 8'd1;
    // Window start L-WINDOW, clamped at 0 when the window is longer than the step.
    assign win_start  = (step_len > WINDOW_L) ? (step_len - WINDOW_L) : 8'd0;
    assign end_marker = (arrows_i == 4'd0) && (timing_i == 4'd0);
    assign rest_step  = (arrows_i == 4'd0);
    assign in_window  = (state_q == S_PLAY) && (step_frame_q >= win_start);

    // -------------------------------------------------------------------------
    // Per-lane press classification. Presses in the current cycle are folded
    // in here so that a press on the step-ending frame still counts.
    // -------------------------------------------------------------------------
    logic [3:0] lane_hit;
    logic [3:0] lane_stray;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi]   = in_window & btn_i[gi] &  arrows_i[gi];
            assign lane_stray[gi] = in_window & btn_i[gi] & ~arrows_i[gi];
        end
    endgenerate

    logic [3:0] pressed_d;
    logic       wrong_d;
    logic       step_hit;

    assign pressed_d = pressed_q | lane_hit;
    assign wrong_d   = wrong_q | (|lane_stray);
    assign step_hit  = (pressed_d == arrows_i) && !wrong_d;

    // -------------------------------------------------------------------------
    // Score / combo / lives arithmetic for a step end
    // -------------------------------------------------------------------------
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_d;
    logic [7:0]         combo_d;
    logic [1:0]         lives_d;

    // Bonus is decided on the combo value before this hit is counted.
    assign score_sum = {1'b0, score_q} + ((combo_q >= 8'd10) ? BONUS_HI : BONUS_LO);
    assign score_d   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    assign combo_d   = (combo_q == 8'hFF) ? combo_q : (combo_q + 8'd1);
    assign lives_d   = lives_q - 2'd1;

    // -------------------------------------------------------------------------
    // Round FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            count_q      <= COUNT_LOAD;
            step_frame_q <= 8'd0;
            pressed_q    <= 4'd0;
            wrong_q      <= 1'b0;
            score_q      <= '0;
            combo_q      <= 8'd0;
            lives_q      <= LIVES_L;
            judge_q      <= JUDGE_NONE;
            next_q       <= 1'b0;
        end else begin
            next_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // Hold a fresh round ready; a frame arriving with start is
                    // deliberately not counted.
                    count_q      <= COUNT_LOAD;
                    step_frame_q <= 8'd0;
                    score_q      <= '0;
                    combo_q      <= 8'd0;
                    judge_q      <= JUDGE_NONE;
                    lives_q      <= LIVES_L;
                    if (start_i) begin
                        state_q <= S_COUNT;
                    end
                end

                S_COUNT: begin
                    if (frame_i) begin
                        if (count_q == 8'd0) begin
                            state_q      <= S_PLAY;
                            step_frame_q <= 8'd0;
                            pressed_q    <= 4'd0;
                            wrong_q      <= 1'b0;
                        end else begin
                            count_q <= count_q - 8'd1;
                        end
                    end
                end

                S_PLAY: begin
                    pressed_q <= pressed_d;
                    wrong_q   <= wrong_d;

                    if (frame_i) begin
                        if (end_marker) begin
                            state_q <= S_DONE;
                        end else if (step_frame_q >= step_last) begin
                            // ">=" rather than "==" so a chart that shortens a
                            // step mid-way still terminates it instead of
                            // letting the frame counter run off.
                            if (rest_step) begin
                                next_q       <= 1'b1;
                                step_frame_q <= 8'd0;
                                pressed_q    <= 4'd0;
                                wrong_q      <= 1'b0;
                            end else if (step_hit) begin
                                judge_q      <= JUDGE_HIT;
                                combo_q      <= combo_d;
                                score_q      <= score_d;
                                next_q       <= 1'b1;
                                step_frame_q <= 8'd0;
                                pressed_q    <= 4'd0;
                                wrong_q      <= 1'b0;
                            end else begin
                                judge_q <= JUDGE_MISS;
                                combo_q <= 8'd0;
                                lives_q <= lives_d;
                                if (lives_d == 2'd0) begin
                                    // Out of lives: the chart is not advanced.
                                    state_q <= S_DONE;
                                end else begin
                                    next_q       <= 1'b1;
                                    step_frame_q <= 8'd0;
                                    pressed_q    <= 4'd0;
                                    wrong_q      <= 1'b0;
                                end
                            end
                        end else begin
                            step_frame_q <= step_frame_q + 8'd1;
                        end
                    end
                end

                S_DONE: begin
                    if (start_i) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign next_o       = next_q;
    assign state_o      = state_q;
    assign step_frame_o = step_frame_q;
    assign score_o      = score_q;
    assign combo_o      = combo_q;
    assign lives_o      = lives_q;
    assign judge_o      = judge_q;

endmodule

// File: tb/tb_ddr_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ddr_game_ctrl
//
// Self-checking bench for ddr_game_ctrl: a table of hand-computed step
// vectors, hand-written sequences for countdown, combo bonus, loss of lives,
// end of chart and asynchronous reset, and randomized rounds checked against
// a step-level reference model of the judging rules.
// -----------------------------------------------------------------------------
module tb_ddr_game_ctrl;

    localparam int CD  = 180;
    localparam int WIN = 8;
    localparam int SW  = 16;
    localparam int NL  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    btn = 4'd0;
    logic [3:0]    arrows = 4'd0;
    logic [3:0]    timing = 4'd0;
    logic          next;
    logic [1:0]    state;
    logic [7:0]    step_frame;
    logic [SW-1:0] score;
    logic [7:0]    combo;
    logic [1:0]    lives;
    logic [1:0]    judge;

    ddr_game_ctrl #(
        .COUNTDOWN_FRAMES(CD),
        .WINDOW          (WIN),
        .SCORE_W         (SW),
        .LIVES           (NL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .frame_i     (frame),
        .start_i     (start),
        .btn_i       (btn),
        .arrows_i    (arrows),
        .timing_i    (timing),
        .next_o      (next),
        .state_o     (state),
        .step_frame_o(step_frame),
        .score_o     (score),
        .combo_o     (combo),
        .lives_o     (lives),
        .judge_o     (judge)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int next_cnt = 0;
    int next_base = 0;

    always @(negedge clk) if (next) next_cnt++;

    // Press schedule for one step: sched[f] is pressed on the frame cycle
    // during which step_frame is f.
    logic [3:0] sched [0:127];

    // Reference model state
    int exp_score, exp_combo, exp_lives, exp_judge, exp_state, exp_next;

    typedef struct {
        logic [3:0] a;
        logic [3:0] t;
        logic [3:0] p;
        int         pf;
        int         ej, es, ec, el, est, en;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched;
        for (int i = 0; i < 128; i++) sched[i] = 4'd0;
    endtask

    task automatic model_reset_round;
        exp_score = 0; exp_combo = 0; exp_lives = NL; exp_judge = 0;
        exp_state = 2; exp_next = 0;
    endtask

    // Judge one step from its arrows, length and press schedule.
    task automatic model_step(input logic [3:0] a, input logic [3:0] t);
        int L, ws;
        logic [3:0] got;
        bit stray;
        L = (int'(t) + 1) * 8;
        ws = (L > WIN) ? L - WIN : 0;
        got = 4'd0;
        stray = 1'b0;
        for (int f = ws; f < L; f++) begin
            got |= sched[f] & a;
            if ((sched[f] & ~a) != 4'd0) stray = 1'b1;
        end
        exp_next = 1;
        exp_state = 2;
        if (a == 4'd0) begin
            // rest step: nothing judged
        end else if (got == a && !stray) begin
            exp_score += (exp_combo >= 10) ? 20 : 10;
            if (exp_score > (1 << SW) - 1) exp_score = (1 << SW) - 1;
            if (exp_combo < 255) exp_combo++;
            exp_judge = 1;
        end else begin
            exp_combo = 0;
            exp_lives--;
            exp_judge = 2;
            if (exp_lives == 0) begin
                exp_next = 0;
                exp_state = 3;
            end
        end
    endtask

    task automatic drive_step(input logic [3:0] a, input logic [3:0] t, input string tag);
        int L;
        L = (int'(t) + 1) * 8;
        arrows = a;
        timing = t;
        next_base = next_cnt;
        for (int f = 0; f < L; f++) begin
            btn = sched[f];
            frame = 1'b1;
            tick;
            frame = 1'b0;
            btn = 4'd0;
            if (f == L / 2 - 1) chk({tag, "_step_frame_mid"}, int'(step_frame), f + 1);
        end
    endtask

    task automatic check_step(input string tag, input int ej, input int es, input int ec,
                              input int el, input int est, input int en);
        chk({tag, "_judge"}, int'(judge), ej);
        chk({tag, "_score"}, int'(score), es);
        chk({tag, "_combo"}, int'(combo), ec);
        chk({tag, "_lives"}, int'(lives), el);
        chk({tag, "_state"}, int'(state), est);
        chk({tag, "_next"}, int'(next), en);
        if (en != 0) chk({tag, "_step_frame_zero"}, int'(step_frame), 0);
        $display("step %s: judge=%0d score=%0d combo=%0d lives=%0d state=%0d next=%0d",
                 tag, judge, score, combo, lives, state, next);
        tick;
        chk({tag, "_next_width"}, int'(next), 0);
        chk({tag, "_next_count"}, next_cnt - next_base, en);
    endtask

    task automatic model_check(input string tag);
        check_step(tag, exp_judge, exp_score, exp_combo, exp_lives, exp_state, exp_next);
    endtask

    // Start from IDLE and run the whole countdown (button noise is ignored).
    task automatic begin_round(input bit with_frame, input string tag);
        next_base = next_cnt;
        start = 1'b1;
        frame = with_frame;
        tick;
        start = 1'b0;
        frame = 1'b0;
        chk({tag, "_cnt_state"}, int'(state), 1);
        chk({tag, "_cnt_score"}, int'(score), 0);
        for (int i = 1; i <= CD; i++) begin
            frame = 1'b1;
            btn = 4'($urandom_range(0, 15));
            tick;
            frame = 1'b0;
            btn = 4'd0;
            if (i == CD - 1) chk({tag, "_cnt_179"}, int'(state), 1);
        end
        chk({tag, "_cnt_180"}, int'(state), 2);
        chk({tag, "_play_step_frame"}, int'(step_frame), 0);
        chk({tag, "_play_lives"}, int'(lives), NL);
        chk({tag, "_play_combo"}, int'(combo), 0);
        chk({tag, "_play_judge"}, int'(judge), 0);
        tick;
        chk({tag, "_cnt_no_next"}, next_cnt - next_base, 0);
        $display("round %s: countdown complete, state=%0d", tag, state);
        model_reset_round;
    endtask

    task automatic end_chart(input string tag);
        int js, ss;
        js = int'(judge);
        ss = int'(score);
        next_base = next_cnt;
        arrows = 4'd0;
        timing = 4'd0;
        frame = 1'b1;
        tick;
        frame = 1'b0;
        chk({tag, "_end_state"}, int'(state), 3);
        chk({tag, "_end_judge"}, int'(judge), js);
        chk({tag, "_end_score"}, int'(score), ss);
        tick;
        chk({tag, "_end_no_next"}, next_cnt - next_base, 0);
        $display("round %s: end of chart, state=%0d", tag, state);
    endtask

    task automatic to_idle(input string tag);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_idle"}, int'(state), 0);
        tick;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        tick;
        tick;
        chk("rst_state", int'(state), 0);
        chk("rst_next", int'(next), 0);
        chk("rst_step_frame", int'(step_frame), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_combo", int'(combo), 0);
        chk("rst_lives", int'(lives), NL);
        chk("rst_judge", int'(judge), 0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        // ---------------- table-driven round ----------------
        tbl[0] = '{4'b0001, 4'd0, 4'b0001,  3, 1, 10, 1, 3, 2, 1}; // hit
        tbl[1] = '{4'b0001, 4'd0, 4'b0011,  5, 2, 10, 0, 2, 2, 1}; // wrong lane
        tbl[2] = '{4'b0110, 4'd1, 4'b0110, 15, 1, 20, 1, 2, 2, 1}; // press on end frame
        tbl[3] = '{4'b0001, 4'd3, 4'b0001, 10, 2, 20, 0, 1, 2, 1}; // press before window
        tbl[4] = '{4'b0000, 4'd2, 4'b0100, 20, 2, 20, 0, 1, 2, 1}; // rest step
        tbl[5] = '{4'b1000, 4'd0, 4'b1000,  7, 1, 30, 1, 1, 2, 1}; // hit
        tbl[6] = '{4'b1000, 4'd0, 4'b0000,  0, 2, 30, 0, 0, 3, 0}; // last life lost

        begin_round(1'b0, "tbl");
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            clear_sched;
            sched[tbl[i].pf] = tbl[i].p;
            drive_step(tbl[i].a, tbl[i].t, tag);
            check_step(tag, tbl[i].ej, tbl[i].es, tbl[i].ec, tbl[i].el, tbl[i].est, tbl[i].en);
        end
        to_idle("tbl");

        // ---------------- combo bonus and loss of lives ----------------
        begin_round(1'b1, "combo");
        clear_sched;
        sched[2] = 4'b0001;
        for (int k = 1; k <= 11; k++) begin
            drive_step(4'b0001, 4'd0, $sformatf("hit%0d", k));
            model_step(4'b0001, 4'd0);
            if (k == 10) chk("combo_score10", int'(score), 100);
            if (k == 11) chk("combo_score11", int'(score), 120);
            model_check($sformatf("hit%0d", k));
        end
        clear_sched;
        for (int k = 1; k <= 3; k++) begin
            drive_step(4'b0010, 4'd0, $sformatf("miss%0d", k));
            model_step(4'b0010, 4'd0);
            model_check($sformatf("miss%0d", k));
        end
        chk("lives_done_state", int'(state), 3);
        chk("lives_done_score", int'(score), 120);
        to_idle("combo");

        // ---------------- end of chart ----------------
        begin_round(1'b0, "eoc");
        clear_sched;
        sched[4] = 4'b0100;
        drive_step(4'b0100, 4'd0, "eoc_hit");
        model_step(4'b0100, 4'd0);
        model_check("eoc_hit");
        end_chart("eoc");
        to_idle("eoc");

        // ---------------- asynchronous reset mid-PLAY ----------------
        begin_round(1'b0, "rst");
        clear_sched;
        sched[0] = 4'b1000;
        drive_step(4'b1000, 4'd0, "rst_hit");
        chk("rst_pre_next", int'(next), 1);
        chk("rst_pre_score", int'(score), 10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_score", int'(score), 0);
        chk("arst_combo", int'(combo), 0);
        chk("arst_lives", int'(lives), NL);
        chk("arst_next", int'(next), 0);
        chk("arst_judge", int'(judge), 0);
        $display("reset mid-play: state=%0d score=%0d lives=%0d", state, score, lives);
        @(negedge clk);
        rst = 1'b0;
        tick;

        // ---------------- combo saturation ----------------
        begin_round(1'b0, "sat");
        clear_sched;
        sched[7] = 4'b1111;
        for (int k = 1; k <= 257; k++) begin
            drive_step(4'b1111, 4'd0, $sformatf("sat%0d", k));
            model_step(4'b1111, 4'd0);
            model_check($sformatf("sat%0d", k));
        end
        chk("sat_combo", int'(combo), 255);
        end_chart("sat");
        to_idle("sat");

        // ---------------- randomized rounds ----------------
        for (int r = 0; r < 5; r++) begin
            begin_round(r[0], $sformatf("rnd%0d", r));
            for (int s = 0; s < 30 && exp_state == 2; s++) begin
                logic [3:0] a, t;
                int L, ws, mode;
                string tag;
                tag = $sformatf("r%0ds%0d", r, s);
                a = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                t = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                if (a == 4'd0 && t == 4'd0) t = 4'd1;
                L = (int'(t) + 1) * 8;
                ws = (L > WIN) ? L - WIN : 0;
                clear_sched;
                mode = $urandom_range(0, 9);
                if (mode < 6) begin
                    // intended hit, possibly split across two frames
                    int f1, f2;
                    f1 = $urandom_range(ws, L - 1);
                    f2 = $urandom_range(ws, L - 1);
                    sched[f1] |= a & 4'($urandom_range(0, 15));
                    sched[f2] |= a;
                end else if (mode < 8) begin
                    for (int j = 0; j < 3; j++)
                        sched[$urandom_range(0, L - 1)] |= 4'($urandom_range(0, 15));
                end else if (ws > 0) begin
                    sched[$urandom_range(0, ws - 1)] = a;
                end
                if ($urandom_range(0, 7) == 0) begin
                    // stray start in PLAY must be ignored
                    start = 1'b1;
                    tick;
                    start = 1'b0;
                end
                drive_step(a, t, tag);
                model_step(a, t);
                model_check(tag);
            end
            if (exp_state == 2) end_chart($sformatf("rnd%0d", r));
            to_idle($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_game_ctrl.md
# ddr_game_ctrl

Game sequencer for the DDR design. Runs the round flow idle → countdown → play → done. Advances the chart one step at a time using its per-step timing and judges the debounced lane presses against each step's required arrows. Keeps score, combo and lives. Sits between the debounce instances, `chart` and `arrow_logic` in the pixel-clock domain. Its `next_o` replaces the AND-of-buttons chart advance.

## Interface
- `COUNTDOWN_FRAMES`, 180: frames spent in COUNT before play starts (1..255).
- `WINDOW`, 8: frames before step end during which presses count (1..128).
- `SCORE_W`, 16: score width.
- `LIVES`, 3: misses allowed per round (1..3).

- `clk_i`, in, 1: pixel clock, the only clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `frame_i`, in, 1: one-cycle pulse per frame, at start of vertical blanking.
- `start_i`, in, 1: one-cycle debounced start pulse.
- `btn_i`, in, 4: one-cycle press pulses, bit order {right, down, up, left}.
- `arrows_i`, in, 4: required arrows of the current chart step.
- `timing_i`, in, 4: current step length code; step length L = (timing_i+1)*8 frames.
- `next_o`, out, 1: one-cycle pulse that advances the chart.
- `state_o`, out, 2: IDLE=0, COUNT=1, PLAY=2, DONE=3.
- `step_frame_o`, out, 8: frames elapsed in the current step; drives scroll position.
- `score_o`, out, SCORE_W: accumulated score.
- `combo_o`, out, 8: consecutive hits.
- `lives_o`, out, 2: remaining lives.
- `judge_o`, out, 2: last judgment; 0=none, 1=HIT, 2=MISS.

## Operation
- **End marker:** `arrows_i`=0 together with `timing_i`=0.
- **IDLE**
  - `start_i` → COUNT.
  - Loads the countdown counter with COUNTDOWN_FRAMES-1.
  - Clears score, combo and judge; sets lives to LIVES.
- **COUNT**
  - Each `frame_i` decrements the counter.
  - A `frame_i` while the counter is 0 → PLAY, with `step_frame_o`=0 and the pressed/wrong masks cleared.
- **PLAY, on each `frame_i`**
  - If the end marker is present → DONE. No judgment, no `next_o`.
  - Else if `step_frame_o`==L-1, the step ends (see below).
  - Otherwise `step_frame_o`+1.
- **PLAY, press window**
  - The window is open while `step_frame_o` >= L-WINDOW, clamped to 0.
  - Inside the window, `btn_i` bits that are in `arrows_i` are ORed into the pressed mask.
  - Inside the window, `btn_i` bits that are not in `arrows_i` set the wrong flag.
  - Presses outside the window are ignored.
- **Step end: judgment**
  - `arrows_i`=0 (rest step): no judgment; combo and judge unchanged.
  - Pressed mask == `arrows_i` and wrong flag clear → HIT:
    - combo+1, saturating at 255;
    - score += 20 if combo was >=10 before the increment, else +10; saturates at all-ones.
  - Otherwise → MISS: combo=0, lives-1.
- **Step end: advance**
  - If lives became 0 → DONE, with no `next_o`.
  - Otherwise pulse `next_o`, set `step_frame_o`=0, clear the mask and flag.
- **DONE**
  - Holds score, combo, lives and judge.
  - `start_i` → IDLE. Chart rewind is outside this block.
- **Ignored inputs:** `btn_i` outside PLAY; `start_i` in COUNT and PLAY.

## Timing
- **Reset values:** state IDLE; `next_o`=0, `step_frame_o`=0, score 0, combo 0, judge 0; `lives_o`=LIVES. Applied immediately on `rst_i`, including mid-round.
- **Registered outputs:** all outputs update on the clock edge after the triggering input cycle.
- **`next_o`:** exactly one cycle wide, in the same cycle as the step-end updates of judge, score, combo and lives.
- **Chart settling:** L and the end marker are decoded combinationally from the chart inputs. The chart must present its new step before the next `frame_i`, i.e. within one frame of `next_o`.
- **Press on the step-end cycle:** a `btn_i` press in the same cycle as the step-ending `frame_i` counts toward the ending step.
- **Start and frame together in IDLE:** `start_i` wins; that frame is not counted.
- **COUNT length:** COUNT lasts exactly COUNTDOWN_FRAMES `frame_i` pulses.
- **Score arithmetic:** computed in SCORE_W+1 bits, then clamped.

## Test plan
- **Reset:** assert `rst_i` mid-PLAY → within one cycle `state_o`=0, `score_o`=0, `combo_o`=0, `lives_o`=3, `next_o`=0.
- **Countdown:** `start_i`, then 180 `frame_i` pulses → `state_o`=1 after the 179th pulse and `state_o`=2 after the 180th; `next_o` never asserted.
- **Hit:** `arrows_i`=0001, `timing_i`=0 (L=8); press bit 0 at `step_frame_o`=3 → on the 8th frame `judge_o`=1, `score_o`=10, `combo_o`=1, `next_o` high one cycle, `step_frame_o`=0.
- **Wrong or late press:**
  - `arrows_i`=0001, press 0011 in window → `judge_o`=2, `combo_o`=0, `lives_o`=2.
  - With `timing_i`=3 (L=32), a press at frame 10 (outside the window) → MISS.
- **Combo bonus and loss of lives:**
  - 10 consecutive hits → score 100; 11th hit → score 120.
  - Then 3 misses → `state_o`=3, no `next_o` on the third miss, `score_o` holds 120.
- **End of chart:** `arrows_i`=0, `timing_i`=0 in PLAY on a `frame_i` → `state_o`=3, judge and score unchanged; `start_i` → `state_o`=0.
